// File: rtl/seq_scan_pkg.sv
// Shared types, default sizes and helpers for the serial sequence scan controller.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } scan_state_t;

  localparam int DEF_WORD_W = 16;
  localparam int DEF_PAT_W  = 4;
  localparam int DEF_CNT_W  = 5;

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Reusable serial pattern detector: PAT_W-bit history, saturating fill count,
// compare against the pattern and optional restart after a match (non-overlap).
module seq_match_core
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_p0;
  logic [PAT_W-1:0]  hist_next;
  logic [FILL_W-1:0] fill_p0;
  logic [FILL_W-1:0] fill_next;

  // Match is judged on the history as it stands after absorbing bit_in.
  always_comb begin
    hist_next = {hist_p0[PAT_W-2:0], bit_in};
    fill_next = (fill_p0 == FILL_W'(PAT_W)) ? fill_p0 : fill_p0 + 1'b1;
    hit       = bit_valid && (fill_next == FILL_W'(PAT_W)) && (hist_next == pattern);
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      hist_p0 <= '0;
      fill_p0 <= '0;
    end else if (bit_valid) begin
      hist_p0 <= hist_next;
      fill_p0 <= (hit && !overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Frame controller: serializes a word MSB-first through seq_match_core and
// records hit positions/count. Define SEQ_SCAN_ABORT_EN to add the abort input.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef SEQ_SCAN_ABORT_EN
  input  logic              abort,
`endif
  input  logic [WORD_W-1:0] word_in,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              overlap,
  output logic              busy,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              hit,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic [WORD_W-1:0] hit_mask
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  scan_state_t       state;
  logic [WORD_W-1:0] word_p0;
  logic [PAT_W-1:0]  pat_p0;
  logic              ovl_p0;
  logic [IDX_W-1:0]  idx_p0;
  logic              start_acc;
  logic              core_clr;

  assign start_acc = (state == IDLE) && start;
`ifdef SEQ_SCAN_ABORT_EN
  assign core_clr  = start_acc || (busy && abort);
`else
  assign core_clr  = start_acc;
`endif

  assign ser_valid = busy;
  assign ser_bit   = busy & word_p0[idx_p0];

  seq_match_core #(
    .PAT_W(PAT_W)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .clr       (core_clr),
    .bit_in    (ser_bit),
    .bit_valid (busy),
    .pattern   (pat_p0),
    .overlap   (ovl_p0),
    .hit       (hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit_count <= '0;
      hit_mask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            word_p0   <= word_in;
            pat_p0    <= pattern;
            ovl_p0    <= overlap;
            idx_p0    <= IDX_W'(WORD_W - 1);
            hit_count <= '0;
            hit_mask  <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
`ifdef SEQ_SCAN_ABORT_EN
          if (abort) begin
            busy      <= 1'b0;
            hit_count <= '0;
            hit_mask  <= '0;
            state     <= IDLE;
          end else
`endif
          begin
            if (hit) begin
              hit_mask[idx_p0] <= 1'b1;
              hit_count        <= CNT_W'(sat_inc(32'(hit_count), CNT_W));
            end
            if (idx_p0 == '0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx_p0 <= idx_p0 - 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Frame-level controller for the serial sequence detector. It accepts a parallel data word and a programmable bit pattern, then serializes the word MSB-first through a pattern-match core, one bit per clock. It records where matches complete, counts them, and reports completion with a one-cycle `done` pulse. It sits between a register/host interface and the serial detection datapath, sequencing each scan and holding the results for the host.

## Interface
- `WORD_W`, 16: data word width, bits scanned per frame (≥ PAT_W)
- `PAT_W`, 4: pattern length in bits (≥ 2)
- `CNT_W`, 5: hit counter width
- `clk` input 1: clock, all logic on rising edge
- `reset` input 1: synchronous, active-high; one clock, reset is synchronous and active-high
- `start` input 1: request a scan, sampled only in IDLE
- `word_in` input WORD_W: word to scan, latched on accepted start
- `pattern` input PAT_W: pattern to detect, latched on accepted start; pattern[PAT_W-1] is the first (oldest) bit
- `overlap` input 1: 1 = overlapping matches, 0 = non-overlapping; latched on accepted start
- `abort` input 1: present only with SEQ_SCAN_ABORT_EN
- `busy` output 1: high in SHIFT
- `ser_bit` output 1: current serialized bit
- `ser_valid` output 1: ser_bit is valid this cycle
- `hit` output 1: pulse, a match completed on the current bit
- `done` output 1: one-cycle pulse at end of scan
- `hit_count` output CNT_W: matches in last scan, saturating
- `hit_mask` output WORD_W: bit i set when a match completed on word bit i

## Operation
- FSM states are IDLE, SHIFT and DONE.
  - IDLE→SHIFT on `start`.
  - SHIFT→DONE after WORD_W bits.
  - DONE→IDLE unconditionally.
- Accepted start:
  - Latch word, pattern and overlap.
  - Clear the history, `hit_count` and `hit_mask`.
  - Load the bit index with WORD_W-1.
- `start` outside IDLE is ignored. This includes a start in the DONE cycle.
- Each SHIFT cycle, the bit `word[idx]` is presented on `ser_bit` with `ser_valid`=1. It is pushed into a PAT_W history with a fill count saturating at PAT_W.
- `hit` is combinational from the updated history: fill count == PAT_W and history == pattern.
- On `hit`:
  - Set `hit_mask[idx]`.
  - Increment `hit_count`, saturating at 2^CNT_W-1.
  - If overlap=0, clear the fill count to 0, so the next match needs PAT_W fresh bits.
- The first PAT_W-1 bits of a frame can never produce a hit. History never carries over between frames.
- `hit_count` and `hit_mask` hold their values from DONE until the next accepted start.
- Reset values: FSM IDLE; `busy`, `ser_bit`, `ser_valid`, `hit` and `done` are 0; `hit_count` and `hit_mask` are 0.
- Reset during SHIFT or DONE returns to IDLE next edge, clears all results, and produces no `done`.

## Timing
- `start` is sampled at edge 0.
- SHIFT covers cycles 1..WORD_W. Bit idx is presented in cycle WORD_W-idx.
- `hit` is in the same cycle as the completing bit.
- `hit_count` and `hit_mask` update at the end of that cycle.
- `done`=1 in cycle WORD_W+1, with `busy`=0 and final results valid.
- Earliest next accepted start is in cycle WORD_W+2.
- Total latency is WORD_W+1 cycles from start to done.

## Configuration
- `SEQ_SCAN_ABORT_EN` defined:
  - `abort` port exists.
  - `abort`=1 in SHIFT returns to IDLE next edge.
  - It clears `hit_count` and `hit_mask` and produces no `done`.
  - `abort` in IDLE or DONE is ignored.
  - `abort` has priority over the last-bit SHIFT→DONE transition.
- `SEQ_SCAN_ABORT_EN` undefined: no `abort` port; a scan always completes.

## Structure
- Package `seq_scan_pkg` holds:
  - the state typedef (IDLE, SHIFT, DONE);
  - default parameter constants;
  - the saturating-increment function.
- Sub-module `seq_match_core` holds the PAT_W history, the fill counter, the compare, and the overlap clear.
  - Inputs: `clk`, `reset`, `clr`, `bit_in`, `bit_valid`, `pattern`, `overlap`.
  - Output: `hit`.
  - This is the reusable serial detector.
- `seq_scan_ctrl` holds the FSM, the index counter and the result registers.

## Test plan
Defaults throughout, pattern 4'b1011, unless stated otherwise.
- **Single match:** word 16'hB000, overlap=1.
  - `hit` in cycle 4 only.
  - `done` in cycle 17.
  - `hit_count`=1, `hit_mask`=16'h1000.
- **Overlap on:** word 16'hB6C0, overlap=1.
  - Hits at bits 12, 9 and 6.
  - `hit_count`=3, `hit_mask`=16'h1240.
- **Overlap off:** word 16'hB6C0, overlap=0.
  - Hits at bits 12 and 6.
  - `hit_count`=2, `hit_mask`=16'h1040.
- **Saturation:** CNT_W=3, pattern 4'b1111, word 16'hFFFF, overlap=1.
  - `hit_mask`=16'h1FFF.
  - `hit_count`=7, saturated.
- **Busy start and mid-scan reset:** start pulsed in cycle 5 is ignored, and `done` still arrives in cycle 17.
  - Separately, `reset` in cycle 8 gives IDLE with all outputs 0 and no `done`.
  - A new start afterwards then scans cleanly.
- **Abort (SEQ_SCAN_ABORT_EN only):** `abort` in cycle 10.
  - IDLE next cycle, `busy`=0, no `done`.
  - `hit_count`=0, `hit_mask`=0.
